// File: rtl/sample_timebase_pkg.sv
// Shared types, default parameters and the elaboration-time period formula for sample_timebase.
package sample_timebase_pkg;

    localparam int unsigned DEF_CNT_W      = 32;
    localparam int unsigned DEF_SCALE_W    = 5;
    localparam int unsigned DEF_NUM_SCALES = 16;
    localparam int unsigned DEF_BASE_DIV   = 100;
    localparam int unsigned DEF_LEN_W      = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Period for scale code s (1-based): base_div * {1,2,4}[(s-1)%3] * 10^((s-1)/3).
    function automatic logic [63:0] period_calc(input int unsigned scale, input int unsigned base_div);
        logic [63:0] p;
        int unsigned idx;
        int unsigned dec;
        if (scale == 0) begin
            return 64'd0;
        end
        idx = scale - 1;
        dec = idx / 3;
        if ((idx % 3) == 0) begin
            p = 64'(base_div);
        end else if ((idx % 3) == 1) begin
            p = 64'(base_div) * 64'd2;
        end else begin
            p = 64'(base_div) * 64'd4;
        end
        for (int unsigned i = 0; i < dec; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

endpackage

// File: rtl/sample_timebase_period_rom.sv
// Combinational scale-code to period lookup; out-of-range codes fall back to the slowest entry.
module period_rom
    import sample_timebase_pkg::*;
#(
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter int unsigned SCALE_W    = DEF_SCALE_W,
    parameter int unsigned NUM_SCALES = DEF_NUM_SCALES,
    parameter int unsigned BASE_DIV   = DEF_BASE_DIV
) (
    input  logic [SCALE_W-1:0] scale,
    output logic [CNT_W-1:0]   period_c,
    output logic               invalid_c
);

    localparam logic [CNT_W-1:0] SLOWEST = CNT_W'(period_calc(NUM_SCALES, BASE_DIV));

    logic [NUM_SCALES:1] hit;
    logic [CNT_W-1:0]    chain [0:NUM_SCALES];

    assign chain[0] = '0;

    // One constant entry per code; the OR chain selects the single matching entry.
    for (genvar s = 1; s <= int'(NUM_SCALES); s++) begin : g_rom
        localparam logic [63:0] ENTRY = period_calc(32'(s), BASE_DIV);

        if ((ENTRY >> CNT_W) != 64'd0) begin : g_ovf
            $error("period table entry %0d does not fit in CNT_W bits", s);
        end

        assign hit[s]   = (32'(scale) == 32'(s));
        assign chain[s] = chain[s-1] | (hit[s] ? CNT_W'(ENTRY) : '0);
    end

    assign invalid_c = ~|hit;
    assign period_c  = invalid_c ? SLOWEST : chain[NUM_SCALES];

endmodule

// File: rtl/sample_timebase.sv
// Programmable sampling timebase: emits tick strobes every period(scale) cycles, grouped into frames.
module sample_timebase
    import sample_timebase_pkg::*;
#(
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter int unsigned SCALE_W    = DEF_SCALE_W,
    parameter int unsigned NUM_SCALES = DEF_NUM_SCALES,
    parameter int unsigned BASE_DIV   = DEF_BASE_DIV,
    parameter int unsigned LEN_W      = DEF_LEN_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               start,
    input  logic               mode,
    input  logic [SCALE_W-1:0] scale_in,
    input  logic [LEN_W-1:0]   frame_len,
    output logic               tick,
    output logic [LEN_W-1:0]   tick_idx,
    output logic               frame_done,
    output logic               busy,
    output logic [CNT_W-1:0]   period_out,
    output logic               scale_err
);

    localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(period_calc(NUM_SCALES, BASE_DIV));

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              mode_q, mode_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic              err_q, err_d;
    logic              tick_q, tick_d;
    logic              done_q, done_d;
    logic [LEN_W-1:0]  tick_idx_q, tick_idx_d;
    logic              busy_q, busy_d;

    logic [CNT_W-1:0]  rom_period_c;
    logic              rom_invalid_c;
    logic [LEN_W-1:0]  last_idx_c;
    logic              wrap_c;
    logic              frame_end_c;

    period_rom #(
        .CNT_W      (CNT_W),
        .SCALE_W    (SCALE_W),
        .NUM_SCALES (NUM_SCALES),
        .BASE_DIV   (BASE_DIV)
    ) u_period_rom (
        .scale     (scale_in),
        .period_c  (rom_period_c),
        .invalid_c (rom_invalid_c)
    );

    // A zero frame length behaves as a one-tick frame.
    assign last_idx_c  = (len_q == '0) ? '0 : len_q - LEN_W'(1);
    assign wrap_c      = (cnt_q == period_q - CNT_W'(1));
    assign frame_end_c = (idx_q >= last_idx_c);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            len_q      <= '0;
            mode_q     <= 1'b0;
            period_q   <= RST_PERIOD;
            err_q      <= 1'b0;
            tick_q     <= 1'b0;
            done_q     <= 1'b0;
            tick_idx_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            mode_q     <= mode_d;
            period_q   <= period_d;
            err_q      <= err_d;
            tick_q     <= tick_d;
            done_q     <= done_d;
            tick_idx_q <= tick_idx_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        len_d      = len_q;
        mode_d     = mode_q;
        period_d   = period_q;
        err_d      = err_q;
        tick_d     = 1'b0;
        done_d     = 1'b0;
        tick_idx_d = tick_idx_q;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d      = '0;
                idx_d      = '0;
                tick_idx_d = '0;
                if (en && start) begin
                    state_d  = ST_RUN;
                    period_d = rom_period_c;
                    err_d    = rom_invalid_c;
                    len_d    = frame_len;
                    mode_d   = mode;
                end
            end
            ST_RUN: begin
                // A finished single frame leaves RUN the cycle after its frame_done.
                if (!en || (done_q && mode_q)) begin
                    state_d    = ST_IDLE;
                    cnt_d      = '0;
                    idx_d      = '0;
                    tick_idx_d = '0;
                end else if (wrap_c) begin
                    cnt_d      = '0;
                    tick_d     = 1'b1;
                    done_d     = frame_end_c;
                    tick_idx_d = idx_q;
                    idx_d      = frame_end_c ? '0 : idx_q + LEN_W'(1);
                    // Rate and length only change on interval boundaries.
                    period_d   = rom_period_c;
                    err_d      = rom_invalid_c;
                    len_d      = frame_len;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN);
    end

    assign tick       = tick_q;
    assign tick_idx   = tick_idx_q;
    assign frame_done = done_q;
    assign busy       = busy_q;
    assign period_out = period_q;
    assign scale_err  = err_q;

endmodule

// File: tb/tb_sample_timebase.sv
// Self-checking bench for sample_timebase: directed scenarios plus randomized runs against a deadline-based model.
module tb_sample_timebase;

    localparam int unsigned CNT_W      = 32;
    localparam int unsigned SCALE_W    = 5;
    localparam int unsigned NUM_SCALES = 16;
    localparam int unsigned BASE_DIV   = 4;
    localparam int unsigned LEN_W      = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic               start;
    logic               mode;
    logic [SCALE_W-1:0] scale_in;
    logic [LEN_W-1:0]   frame_len;
    logic               tick;
    logic [LEN_W-1:0]   tick_idx;
    logic               frame_done;
    logic               busy;
    logic [CNT_W-1:0]   period_out;
    logic               scale_err;

    always #5 clk = ~clk;

    sample_timebase #(
        .CNT_W      (CNT_W),
        .SCALE_W    (SCALE_W),
        .NUM_SCALES (NUM_SCALES),
        .BASE_DIV   (BASE_DIV),
        .LEN_W      (LEN_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .start      (start),
        .mode       (mode),
        .scale_in   (scale_in),
        .frame_len  (frame_len),
        .tick       (tick),
        .tick_idx   (tick_idx),
        .frame_done (frame_done),
        .busy       (busy),
        .period_out (period_out),
        .scale_err  (scale_err)
    );

    int checks   = 0;
    int failures = 0;
    int tick_count;

    // Periods for codes 1..16 with a base divider of 4.
    int exp_tab [16] = '{4, 8, 16, 40, 80, 160, 400, 800, 1600, 4000,
                         8000, 16000, 40000, 80000, 160000, 400000};

    longint cyc = 0;
    bit     m_run, m_stop, m_mode, m_err, m_tick, m_done;
    longint m_deadline;
    int     m_pos, m_len, m_per, m_idx;

    function automatic int ref_period(input int s);
        if (s < 1 || s > 16) return exp_tab[15];
        return exp_tab[s-1];
    endfunction

    function automatic bit ref_invalid(input int s);
        return (s < 1 || s > 16);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference behaviour: each interval ends at an absolute deadline set when it begins.
    task automatic model_edge(input bit r, input bit e, input bit s, input bit md,
                              input int sc, input int ln);
        m_tick = 0;
        m_done = 0;
        if (r) begin
            m_run = 0; m_stop = 0; m_idx = 0; m_per = exp_tab[15]; m_err = 0;
        end else if (!m_run) begin
            m_idx = 0;
            if (e && s) begin
                m_run = 1; m_stop = 0;
                m_per = ref_period(sc); m_err = ref_invalid(sc);
                m_len = (ln == 0) ? 1 : ln; m_mode = md;
                m_pos = 0; m_deadline = cyc + m_per;
            end
        end else if (!e || m_stop) begin
            m_run = 0; m_stop = 0; m_idx = 0;
        end else if (cyc == m_deadline) begin
            m_tick = 1;
            m_idx  = m_pos;
            m_done = (m_pos >= m_len - 1);
            m_pos  = m_done ? 0 : m_pos + 1;
            m_per  = ref_period(sc); m_err = ref_invalid(sc);
            m_len  = (ln == 0) ? 1 : ln;
            m_deadline = cyc + m_per;
            if (m_done && m_mode) m_stop = 1;
        end
    endtask

    task automatic step();
        bit i_rst = rst;
        bit i_en  = en;
        bit i_st  = start;
        bit i_md  = mode;
        int i_sc  = int'(scale_in);
        int i_ln  = int'(frame_len);
        @(posedge clk);
        cyc++;
        model_edge(i_rst, i_en, i_st, i_md, i_sc, i_ln);
        #1;
        if (tick === 1'b1) tick_count++;
        chk("tick",       64'(tick),       64'(m_tick));
        chk("frame_done", 64'(frame_done), 64'(m_done));
        chk("busy",       64'(busy),       64'(m_run));
        chk("tick_idx",   64'(tick_idx),   64'(m_idx));
        chk("period_out", 64'(period_out), 64'(m_per));
        chk("scale_err",  64'(scale_err),  64'(m_err));
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic start_frame(input int s, input int len, input int md);
        scale_in  = SCALE_W'(s);
        frame_len = LEN_W'(len);
        mode      = md[0];
        en        = 1'b1;
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; start = 1'b1; mode = 1'b0;
        scale_in = 5'd1; frame_len = 16'd3; tick_count = 0;

        // Reset, with start held high to show it is ignored.
        run(2);
        chk("rst_period", 64'(period_out), 64'd400000);
        chk("rst_busy",   64'(busy),       64'd0);
        rst = 1'b0; start = 1'b0;
        run(2);

        // Single frames of three ticks at the four fastest rates.
        for (int s = 1; s <= 4; s++) begin
            tick_count = 0;
            start_frame(s, 3, 1);
            run(3 * ref_period(s) + 3);
            chk("frame_ticks", 64'(tick_count), 64'd3);
            chk("idle_after",  64'(busy),       64'd0);
        end

        // Invalid codes select the slowest period and flag an error; a valid code clears it.
        start_frame(0, 1, 1);
        chk("err0_period", 64'(period_out), 64'd400000);
        chk("err0_flag",   64'(scale_err),  64'd1);
        run(3); en = 1'b0; step(); en = 1'b1; step();
        start_frame(20, 1, 1);
        chk("err20_period", 64'(period_out), 64'd400000);
        chk("err20_flag",   64'(scale_err),  64'd1);
        run(3); en = 1'b0; step(); en = 1'b1; step();
        start_frame(2, 1, 1);
        chk("err_clear",  64'(scale_err),  64'd0);
        chk("err_clear_p", 64'(period_out), 64'd8);
        run(12);

        // Continuous frames with a rate change in the middle of the first interval.
        tick_count = 0;
        start_frame(1, 2, 0);
        run(2);
        scale_in = 5'd3;
        run(60);
        chk("rate_change_ticks", 64'(tick_count), 64'd4);
        en = 1'b0; step(); en = 1'b1; step();

        // Enable dropped two cycles ahead of the first tick.
        tick_count = 0;
        start_frame(2, 3, 1);
        run(5);
        en = 1'b0;
        step();
        chk("abort_idx",  64'(tick_idx), 64'd0);
        chk("abort_busy", 64'(busy),     64'd0);
        run(6);
        chk("abort_ticks", 64'(tick_count), 64'd0);
        en = 1'b1; step();

        // Start ignored while running; reset mid-frame aborts it.
        start_frame(1, 3, 1);
        run(2);
        start = 1'b1; step(); start = 1'b0;
        run(6);
        rst = 1'b1; start = 1'b1;
        step();
        chk("midrst_busy",   64'(busy),       64'd0);
        chk("midrst_idx",    64'(tick_idx),   64'd0);
        chk("midrst_period", 64'(period_out), 64'd400000);
        chk("midrst_done",   64'(frame_done), 64'd0);
        rst = 1'b0; start = 1'b0;
        run(3);

        // Zero frame length gives a single one-tick frame.
        tick_count = 0;
        start_frame(1, 0, 1);
        run(8);
        chk("len0_ticks", 64'(tick_count), 64'd1);

        // Randomized runs with rate/length changes, stray starts and rare enable drops.
        for (int it = 0; it < 10; it++) begin
            start_frame(int'($urandom_range(1, 4)), int'($urandom_range(0, 4)), int'($urandom_range(0, 1)));
            for (int c = 0; c < 120; c++) begin
                if ($urandom_range(0, 15) == 0) scale_in  = SCALE_W'($urandom_range(1, 4));
                if ($urandom_range(0, 15) == 0) frame_len = LEN_W'($urandom_range(0, 4));
                start = ($urandom_range(0, 9) == 0);
                en    = ($urandom_range(0, 63) != 0);
                step();
            end
            start = 1'b0; en = 1'b0;
            step();
            en = 1'b1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
